pc_return_stack: RTL and testbench
==================================

// Module: pc_return_stack
// PURPOSE
//  Program counter register plus hardware return-address stack for the RAT CPU.
//  - Consumes DIN, the next-PC value from the PC source mux.
//  - Drives FROM_STACK back into that mux, so CALL/RET need no scratch-RAM cycles.
//  - Sits between the PC source mux and the program ROM address.
// PARAMETERS
//  WIDTH       10      PC/address width in bits
//  DEPTH       8       return-stack entries (power of 2, >=2)
//  RESET_ADDR  10'h000 PC value after reset
// PORTS
//  CLK         in   1      rising-edge clock
//  RST_N       in   1      synchronous reset, active-low
//  DIN         in   WIDTH  next PC value from the PC source mux
//  PC_LD       in   1      load PC from DIN
//  PC_INC      in   1      increment PC
//  PUSH        in   1      push return address (CALL)
//  POP         in   1      pop top of stack (RET)
//  PC_COUNT    out  WIDTH  current PC, drives ROM address
//  FROM_STACK  out  WIDTH  top-of-stack value, combinational from state
//  STK_FULL    out  1      stack holds DEPTH entries
//  STK_EMPTY   out  1      stack holds 0 entries
//  STK_ERR     out  1      sticky protocol/overflow/underflow error
// BEHAVIOUR
//  Reset (RST_N=0 at a clock edge):
//  - PC_COUNT=RESET_ADDR, count=0, STK_ERR=0.
//  - Stack contents are not cleared.
//  PC register:
//  - PC_LD has priority over PC_INC.
//  - PC_INC adds 1 modulo 2^WIDTH (3FF -> 000). Neither asserted: hold.
//  - All updates take effect one cycle after the inputs are sampled.
//  Stack:
//  - Backed by DEPTH x WIDTH register array and pointer sp, with count in 0..DEPTH.
//  - PUSH writes PC_COUNT+1 (mod 2^WIDTH), sampled before any PC update in the same cycle.
//  - POP decrements count at the edge.
//  - FROM_STACK shows the popped value during the POP cycle, so the mux selects it
//    combinationally with PC_LD=1 and POP=1 in that same cycle.
//  - FROM_STACK = top entry when count>0, else 0.
//  - STK_EMPTY = (count==0). STK_FULL = (count==DEPTH). Both are registered-state derived,
//    with no combinational path from inputs.
//  Boundary conditions:
//  - PUSH when full: see CONFIGURATION.
//  - POP when empty: ignored, count stays 0, STK_ERR<=1.
//  - PUSH and POP together: stack unchanged, STK_ERR<=1. PC still updates normally.
//  - STK_ERR stays set until reset. It does not block later valid operations.
//  - Reset asserted mid-operation wins over all other inputs in that cycle.
// CONFIGURATION
//  Macro PC_STACK_CIRC_EN:
//  - Undefined: PUSH when full is ignored, contents and count unchanged, STK_ERR<=1.
//  - Defined: stack is circular. PUSH when full overwrites the oldest entry,
//    sp wraps modulo DEPTH, count stays DEPTH, STK_ERR unaffected.
//    A later POP returns the newest entries; after DEPTH pops, count=0.
// TESTING
//  1. Hold RST_N=0 one edge, then PC_INC=1 for 3 cycles
//     -> PC_COUNT 000,001,002,003; STK_EMPTY=1; STK_ERR=0.
//  2. PC=3FF, PC_INC=1 -> PC_COUNT=000.
//     PC_LD=1 with PC_INC=1, DIN=155 -> PC_COUNT=155.
//  3. PC=020, PUSH=1 with PC_LD=1, DIN=100 -> PC=100, FROM_STACK=021.
//     Then POP=1, PC_LD=1, DIN=FROM_STACK -> PC=021, STK_EMPTY=1.
//  4. Push 8 distinct addresses -> STK_FULL=1.
//     9th PUSH -> no change, STK_ERR=1 (macro off);
//     or 8 POPs return last 8 in LIFO order, STK_ERR=0 (macro on).
//  5. POP when empty -> STK_ERR=1, FROM_STACK=000, count 0.
//     PUSH+POP together -> count unchanged, STK_ERR=1.
//  6. Push 3 entries, then assert RST_N=0 with PUSH=1
//     -> PC=RESET_ADDR, STK_EMPTY=1, STK_ERR=0 next cycle.

Source files
------------

// File: rtl/pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_return_stack
// Purpose  : PC register with a hardware return-address stack for CALL/RET.
//            Optional circular stack behaviour when PC_STACK_CIRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pc_return_stack #(
   parameter int               WIDTH      = 10,
   parameter int               DEPTH      = 8,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             pc_ld,
   input  logic             pc_inc,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] pc_count,
   output logic [WIDTH-1:0] from_stack,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   localparam int             c_cw    = $clog2(DEPTH + 1);
   localparam int             c_spw   = $clog2(DEPTH);
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_pc;
   logic [c_spw-1:0] r_sp;
   logic [c_cw-1:0]  r_count;
   logic             r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_push_only;
   logic             w_pop_only;
   logic             w_mem_wr;
   logic [WIDTH-1:0] w_ret_addr;
   logic [c_spw-1:0] w_top_idx;

   assign w_full      = (r_count == c_depth);
   assign w_empty     = (r_count == '0);
   assign w_push_only = push && !pop;
   assign w_pop_only  = pop && !push;
   assign w_ret_addr  = r_pc + 1'b1;
   assign w_top_idx   = r_sp - 1'b1;

`ifdef PC_STACK_CIRC_EN
   // A full stack overwrites its oldest slot; sp wraps naturally at DEPTH.
   assign w_mem_wr = w_push_only;
`else
   assign w_mem_wr = w_push_only && !w_full;
`endif

   // Stack contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst_n && w_mem_wr) begin
         r_mem[r_sp] <= w_ret_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc    <= RESET_ADDR;
         r_sp    <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         if (pc_ld) begin
            r_pc <= din;
         end else if (pc_inc) begin
            r_pc <= r_pc + 1'b1;
         end

         if (push && pop) begin
            r_err <= 1'b1;
         end else if (w_push_only) begin
            if (!w_full) begin
               r_sp    <= r_sp + 1'b1;
               r_count <= r_count + 1'b1;
            end else begin
`ifdef PC_STACK_CIRC_EN
               r_sp <= r_sp + 1'b1;
`else
               r_err <= 1'b1;
`endif
            end
         end else if (w_pop_only) begin
            if (!w_empty) begin
               r_sp    <= r_sp - 1'b1;
               r_count <= r_count - 1'b1;
            end else begin
               r_err <= 1'b1;
            end
         end
      end
   end

   assign pc_count   = r_pc;
   assign from_stack = w_empty ? '0 : r_mem[w_top_idx];
   assign stk_full   = w_full;
   assign stk_empty  = w_empty;
   assign stk_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_return_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_return_stack
// Purpose  : Directed self-checking bench for pc_return_stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_return_stack;

   logic       clk;
   logic       rst_n;
   logic [9:0] din;
   logic       pc_ld;
   logic       pc_inc;
   logic       push;
   logic       pop;
   logic [9:0] pc_count;
   logic [9:0] from_stack;
   logic       stk_full;
   logic       stk_empty;
   logic       stk_err;

   int total;
   int bad;

   pc_return_stack #(
      .WIDTH      (10),
      .DEPTH      (8),
      .RESET_ADDR (10'h000)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .pc_ld      (pc_ld),
      .pc_inc     (pc_inc),
      .push       (push),
      .pop        (pop),
      .pc_count   (pc_count),
      .from_stack (from_stack),
      .stk_full   (stk_full),
      .stk_empty  (stk_empty),
      .stk_err    (stk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pc_ld  = 1'b0;
      pc_inc = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      din    = '0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      idle();

      // 1: reset then count up
      tick();
      chk("rst_pc", pc_count, 10'h000);
      chk("rst_empty", stk_empty, 1'b1);
      chk("rst_full", stk_full, 1'b0);
      chk("rst_err", stk_err, 1'b0);
      chk("rst_from_stack", from_stack, 10'h000);
      rst_n  = 1'b1;
      pc_inc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         chk($sformatf("inc_%0d", i), pc_count, 32'(i));
      end
      chk("inc_empty", stk_empty, 1'b1);
      chk("inc_err", stk_err, 1'b0);

      // 2: wrap and load priority
      idle();
      pc_ld = 1'b1; din = 10'h3FF;
      tick();
      chk("ld_3ff", pc_count, 10'h3FF);
      idle();
      pc_inc = 1'b1;
      tick();
      chk("inc_wrap", pc_count, 10'h000);
      pc_ld = 1'b1; pc_inc = 1'b1; din = 10'h155;
      tick();
      chk("ld_over_inc", pc_count, 10'h155);

      // 3: call / return
      idle();
      pc_ld = 1'b1; din = 10'h020;
      tick();
      push = 1'b1; din = 10'h100;
      tick();
      chk("call_pc", pc_count, 10'h100);
      chk("call_top", from_stack, 10'h021);
      chk("call_empty", stk_empty, 1'b0);
      push = 1'b0; pop = 1'b1;
      #1;
      chk("ret_top_comb", from_stack, 10'h021);
      din = from_stack;
      tick();
      chk("ret_pc", pc_count, 10'h021);
      chk("ret_empty", stk_empty, 1'b1);
      chk("ret_err", stk_err, 1'b0);

      // 4: fill; entry i holds 041+16*i
      idle();
      pc_ld = 1'b1; din = 10'h040;
      tick();
      push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fill_full_before_%0d", i), stk_full, 1'b0);
         din = 10'(10'h040 + 16 * (i + 1));
         tick();
         chk($sformatf("fill_top_%0d", i), from_stack, 32'(10'h041 + 16 * i));
      end
      chk("fill_full", stk_full, 1'b1);
      chk("fill_err", stk_err, 1'b0);
      chk("fill_pc", pc_count, 10'h0C0);
      din = 10'h0D0;
      tick();
      chk("ovf_full", stk_full, 1'b1);
      idle();
`ifdef PC_STACK_CIRC_EN
      chk("ovf_err", stk_err, 1'b0);
      chk("ovf_top", from_stack, 10'h0C1);
      pop = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), from_stack, 32'(10'h0C1 - 16 * i));
         tick();
      end
      chk("drain_err", stk_err, 1'b0);
`else
      chk("ovf_err", stk_err, 1'b1);
      chk("ovf_top", from_stack, 10'h0B1);
      pop = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_%0d", i), from_stack, 32'(10'h0B1 - 16 * i));
         tick();
      end
`endif
      chk("drain_empty", stk_empty, 1'b1);
      chk("drain_full", stk_full, 1'b0);

      // 5: underflow and simultaneous push/pop
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst2_err", stk_err, 1'b0);
      pop = 1'b1;
      tick();
      chk("unf_err", stk_err, 1'b1);
      chk("unf_top", from_stack, 10'h000);
      chk("unf_empty", stk_empty, 1'b1);
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push = 1'b1;
      tick();
      chk("one_top", from_stack, 10'h001);
      pop = 1'b1; pc_inc = 1'b1;
      tick();
      chk("pp_err", stk_err, 1'b1);
      chk("pp_top", from_stack, 10'h001);
      chk("pp_empty", stk_empty, 1'b0);
      chk("pp_pc", pc_count, 10'h001);
      idle();
      pop = 1'b1;
      tick();
      chk("pop_after_err", stk_empty, 1'b1);

      // 6: reset beats a concurrent push
      idle();
      push = 1'b1; pc_inc = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("pre_rst_top", from_stack, 10'h004);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_pc", pc_count, 10'h000);
      chk("mid_rst_empty", stk_empty, 1'b1);
      chk("mid_rst_err", stk_err, 1'b0);
      idle();
      rst_n = 1'b1;
      tick();
      chk("post_rst_empty", stk_empty, 1'b1);
      chk("post_rst_top", from_stack, 10'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
